zero_count_frame_accum: RTL and testbench



---
 rtl/zero_count_frame_accum_if.sv | 22 ++
 rtl/zero_count_frame_accum.sv | 171 +++++++++++++++++
 tb/tb_zero_count_frame_accum.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zero_count_frame_accum_if.sv
// Result-record bus of zero_count_frame_accum: FIFO head with a valid/ready handshake.
interface zero_count_frame_accum_if #(
  parameter int unsigned FRAME_W = 8,
  parameter int unsigned ACC_W   = FRAME_W + 6
);
  logic               out_vld;
  logic               out_rdy;
  logic [ACC_W-1:0]   out_sum;
  logic [FRAME_W:0]   out_words;
  logic [5:0]         out_min;
  logic [5:0]         out_max;

  modport master (
    output out_vld, out_sum, out_words, out_min, out_max,
    input  out_rdy
  );

  modport slave (
    input  out_vld, out_sum, out_words, out_min, out_max,
    output out_rdy
  );
endinterface

// File: rtl/zero_count_frame_accum.sv
// Accumulates per-word zero counts over programmable frames and queues one record per frame.
// Define ZERO_COUNT_FRAME_ACCUM_MINMAX_EN to add min/max tracking to each record.
module zero_count_frame_accum #(
  parameter int unsigned FRAME_W = 8,
  parameter int unsigned ACC_W   = FRAME_W + 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FRAME_W-1:0]       cfg_frame_len,
  input  logic                     in_vld,
  input  logic [5:0]               in_cnt,
  input  logic                     flush,
  input  logic                     clr_ovf,
  output logic                     busy,
  output logic                     ovf_r,
  zero_count_frame_accum_if.master out_if
);

  localparam int unsigned WORDS_W = FRAME_W + 1;
  localparam int unsigned CNT_W   = 6;
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(32);
  localparam logic [WORDS_W-1:0] LEN_FULL = {1'b1, {FRAME_W{1'b0}}};

  typedef struct packed {
    logic [ACC_W-1:0]   sum;
    logic [WORDS_W-1:0] words;
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
    logic [CNT_W-1:0]   cnt_min;
    logic [CNT_W-1:0]   cnt_max;
`endif
  } rec_t;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state_q, state_d;
  logic [WORDS_W-1:0] len_q, len_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [WORDS_W-1:0] words_q, words_d;
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
`endif
  logic [CNT_W-1:0]   cnt_c;
  logic               close_c;
  rec_t               rec_c;

  rec_t               mem0_q, mem1_q, head_c;
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         fill_q, fill_d;
  logic               ovf_q;
  logic               pop_c, push_c, drop_c;

  assign cnt_c = (in_cnt > CNT_MAX) ? CNT_MAX : in_cnt;

  // Frame FSM: next state, accumulator update and close detection.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    words_d = words_q;
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
    min_d   = min_q;
    max_d   = max_q;
`endif
    close_c = 1'b0;
    rec_c   = '0;
    case (state_q)
      IDLE: begin
        if (in_vld) begin
          len_d   = (cfg_frame_len == '0) ? LEN_FULL : WORDS_W'(cfg_frame_len);
          sum_d   = ACC_W'(cnt_c);
          words_d = WORDS_W'(1);
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
          min_d   = cnt_c;
          max_d   = cnt_c;
`endif
          if (len_d == WORDS_W'(1) || flush) close_c = 1'b1;
          else                               state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_vld) begin
          sum_d   = sum_q + ACC_W'(cnt_c);
          words_d = words_q + WORDS_W'(1);
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
          min_d   = (cnt_c < min_q) ? cnt_c : min_q;
          max_d   = (cnt_c > max_q) ? cnt_c : max_q;
`endif
          if (words_d == len_q || flush) begin
            close_c = 1'b1;
            state_d = IDLE;
          end
        end else if (flush) begin
          close_c = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rec_c.sum   = sum_d;
    rec_c.words = words_d;
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
    rec_c.cnt_min = min_d;
    rec_c.cnt_max = max_d;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      words_q <= '0;
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
      min_q   <= '0;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      words_q <= words_d;
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
      min_q   <= min_d;
      max_q   <= max_d;
`endif
    end
  end

  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign pop_c  = out_if.out_vld && out_if.out_rdy;
  assign push_c = close_c && ((fill_q != 2'd2) || pop_c);
  assign drop_c = close_c && !push_c;
  assign fill_d = fill_q + 2'(push_c) - 2'(pop_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) begin
        if (wr_ptr_q) mem1_q <= rec_c;
        else          mem0_q <= rec_c;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      fill_q <= fill_d;
      if (drop_c)       ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign head_c           = rd_ptr_q ? mem1_q : mem0_q;
  assign out_if.out_vld   = (fill_q != 2'd0);
  assign out_if.out_sum   = head_c.sum;
  assign out_if.out_words = head_c.words;
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
  assign out_if.out_min   = head_c.cnt_min;
  assign out_if.out_max   = head_c.cnt_max;
`else
  assign out_if.out_min   = '0;
  assign out_if.out_max   = '0;
`endif
  assign busy  = (state_q == ACCUM);
  assign ovf_r = ovf_q;

endmodule

// File: tb/tb_zero_count_frame_accum.sv
// Bench for zero_count_frame_accum: frame vector table plus overflow/reset sequences, scoreboarded records.
module tb_zero_count_frame_accum;

  localparam int unsigned FRAME_W = 8;
  localparam int unsigned ACC_W   = FRAME_W + 6;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [FRAME_W-1:0] cfg_frame_len = '0;
  logic               in_vld = 1'b0;
  logic [5:0]         in_cnt = '0;
  logic               flush = 1'b0;
  logic               clr_ovf = 1'b0;
  logic               busy;
  logic               ovf_r;

  zero_count_frame_accum_if #(.FRAME_W(FRAME_W), .ACC_W(ACC_W)) bus ();

  zero_count_frame_accum #(.FRAME_W(FRAME_W), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_frame_len (cfg_frame_len),
    .in_vld        (in_vld),
    .in_cnt        (in_cnt),
    .flush         (flush),
    .clr_ovf       (clr_ovf),
    .busy          (busy),
    .ovf_r         (ovf_r),
    .out_if        (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int words;
    int mn;
    int mx;
  } exp_t;

  typedef struct {
    logic [7:0]      len;
    int              n;
    logic [7:0][5:0] c;
    bit              fl;
    int              esum;
    int              ewords;
    int              emin;
    int              emax;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic void push_exp(input int s, input int w, input int mn, input int mx);
    exp_t e;
    e.sum = s;
    e.words = w;
`ifdef ZERO_COUNT_FRAME_ACCUM_MINMAX_EN
    e.mn = mn;
    e.mx = mx;
`else
    e.mn = 0;
    e.mx = 0;
`endif
    exp_q.push_back(e);
  endfunction

  // Record checker: a pop happens at the next rising edge, so compare the head now.
  always @(negedge clk) begin
    if (rst && bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rec_sum", bus.out_sum, e.sum);
        chk("rec_words", bus.out_words, e.words);
        chk("rec_min", bus.out_min, e.mn);
        chk("rec_max", bus.out_max, e.mx);
      end
    end
  end

  // One input word; busy is checked one edge later.
  task automatic word(input logic [5:0] c, input logic fl, input bit exp_busy);
    in_vld = 1'b1;
    in_cnt = c;
    flush  = fl;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    flush  = 1'b0;
    chk("busy", busy, exp_busy);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || bus.out_vld) && cyc < 40) begin
      idle_cycle();
      cyc++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  vec_t vt[8];

  initial begin
    vt[0] = '{len: 8'd4, n: 4, c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd7, 6'd5, 6'd0, 6'd32},
              fl: 1'b0, esum: 44, ewords: 4, emin: 0, emax: 32};
    vt[1] = '{len: 8'd8, n: 3, c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd3, 6'd3, 6'd3},
              fl: 1'b1, esum: 9, ewords: 3, emin: 3, emax: 3};
    vt[2] = '{len: 8'd1, n: 1, c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63},
              fl: 1'b0, esum: 32, ewords: 1, emin: 32, emax: 32};
    vt[3] = '{len: 8'd3, n: 3, c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd30, 6'd20, 6'd10},
              fl: 1'b0, esum: 60, ewords: 3, emin: 10, emax: 30};
    vt[4] = '{len: 8'd2, n: 2, c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
              fl: 1'b0, esum: 0, ewords: 2, emin: 0, emax: 0};
    vt[5] = '{len: 8'd5, n: 3, c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd3, 6'd2, 6'd1},
              fl: 1'b1, esum: 6, ewords: 3, emin: 1, emax: 3};
    vt[6] = '{len: 8'd8, n: 8, c: {6'd7, 6'd6, 6'd2, 6'd0, 6'd33, 6'd1, 6'd9, 6'd4},
              fl: 1'b0, esum: 61, ewords: 8, emin: 0, emax: 32};
    vt[7] = '{len: 8'd2, n: 2, c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63, 6'd63},
              fl: 1'b0, esum: 64, ewords: 2, emin: 32, emax: 32};

    bus.out_rdy = 1'b1;

    // Reset state
    #3;
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_words", bus.out_words, 0);
    chk("rst_out_min", bus.out_min, 0);
    chk("rst_out_max", bus.out_max, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_r, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle_cycle();

    // Table of frames, applied back to back
    for (int v = 0; v < 8; v++) begin
      cfg_frame_len = vt[v].len;
      for (int i = 0; i < vt[v].n; i++) begin
        bit last;
        last = (i == vt[v].n - 1);
        if (last) push_exp(vt[v].esum, vt[v].ewords, vt[v].emin, vt[v].emax);
        word(vt[v].c[i], vt[v].fl && last, !last);
        if (i == 0 && !last) cfg_frame_len = 8'd1;
      end
      chk("close_latency_vld", bus.out_vld, 1);
    end
    drain();

    // Flush in IDLE with no word: nothing emitted
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0;
    chk("idle_flush_busy", busy, 0);
    idle_cycle();
    chk("idle_flush_vld", bus.out_vld, 0);

    // Length 0 encodes 256 words
    cfg_frame_len = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) push_exp(8192, 256, 32, 32);
      word(6'd32, 1'b0, i != 255);
    end
    chk("len0_vld", bus.out_vld, 1);
    drain();

    // Back-pressure and overflow
    cfg_frame_len = 8'd1;
    bus.out_rdy = 1'b0;
    push_exp(1, 1, 1, 1);
    word(6'd1, 1'b0, 1'b0);
    push_exp(1, 1, 1, 1);
    word(6'd1, 1'b0, 1'b0);
    chk("ovf_before_drop", ovf_r, 0);
    word(6'd1, 1'b0, 1'b0);
    chk("ovf_after_drop", ovf_r, 1);
    chk("stall_vld", bus.out_vld, 1);
    chk("stall_head_sum", bus.out_sum, 1);
    clr_ovf = 1'b1;
    idle_cycle();
    clr_ovf = 1'b0;
    chk("ovf_cleared", ovf_r, 0);
    clr_ovf = 1'b1;
    word(6'd5, 1'b0, 1'b0);
    clr_ovf = 1'b0;
    chk("ovf_set_wins", ovf_r, 1);
    clr_ovf = 1'b1;
    idle_cycle();
    clr_ovf = 1'b0;
    chk("ovf_cleared2", ovf_r, 0);
    bus.out_rdy = 1'b1;
    push_exp(2, 1, 2, 2);
    word(6'd2, 1'b0, 1'b0);
    chk("full_pop_push_no_ovf", ovf_r, 0);
    drain();

    // Reset mid-frame with a queued record
    bus.out_rdy = 1'b0;
    cfg_frame_len = 8'd1;
    word(6'd7, 1'b0, 1'b0);
    cfg_frame_len = 8'd4;
    word(6'd9, 1'b0, 1'b1);
    word(6'd9, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_vld", bus.out_vld, 0);
    chk("midrst_sum", bus.out_sum, 0);
    chk("midrst_words", bus.out_words, 0);
    chk("midrst_min", bus.out_min, 0);
    chk("midrst_max", bus.out_max, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", ovf_r, 0);
    idle_cycle();
    idle_cycle();
    rst = 1'b1;
    bus.out_rdy = 1'b1;
    idle_cycle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push_exp(4, 4, 1, 1);
      word(6'd1, 1'b0, i != 3);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
